// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access data-memory load/store unit on a req/gnt/rvalid bus
//
// Purpose: accepts one load or store from EX, runs it on the data bus while
// holding the pipeline, and returns the lane-extracted, extended load word.
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   mem_read, mem_write            load / store request from EX
//   funct3, addr, wdata            access width/sign, byte address, store data
//   rd_data, resp_valid            load result, 1-cycle completion pulse
//   stall                          hold the pipeline
//   misaligned, illegal, bus_err   1-cycle error pulses
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata              bus request side
//   bus_gnt, bus_rvalid, bus_rdata bus response side

module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rd_data,
  output logic            resp_valid,
  output logic            stall,
  output logic            misaligned,
  output logic            illegal,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic            req;
  logic            bad_f3;
  logic            misal;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_ext;
  logic            timeout_hit;

  assign req = mem_read | mem_write;

  // Loads accept B/H/W/BU/HU; stores only B/H/W. Asking for both is illegal.
  always_comb begin
    bad_f3 = 1'b0;
    if (mem_read && mem_write) begin
      bad_f3 = 1'b1;
    end else if (mem_read) begin
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else if (mem_write) begin
      bad_f3 = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
    end
  end

  // funct3[1:0] encodes the size for both signed and unsigned loads.
  assign misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << addr[1:0];
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  assign lane_b = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = bus_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  // cnt_q counts completed REQ/WAIT cycles; the cycle that would bring it to
  // TIMEOUT is the last one before the abort.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    stall      = 1'b0;
    resp_valid = 1'b0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_be     = 4'b0000;
    bus_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad_f3) begin
            illegal = 1'b1;
          end else if (misal) begin
            misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            we_d    = mem_write;
            f3_d    = funct3;
            addr_d  = addr;
            be_d    = be_c;
            wdata_d = wdata_c;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[XLEN-1:2], 2'b00};
        bus_be    = be_q;
        bus_wdata = wdata_q;
        cnt_d     = cnt_q + CW'(1);
        if (bus_gnt) begin
          state_d = we_q ? RESP : WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
          if (!we_q) rd_data_d = '0;
        end
      end

      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (bus_rvalid) begin
          rd_data_d = load_ext;
          state_d   = RESP;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          rd_data_d = '0;
          state_d   = RESP;
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        bus_err    = err_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rd_data;
  logic        resp_valid, stall, misaligned, illegal, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  int          r_stall, r_req;
  logic        r_ok, r_err, s_seen, s_we;
  logic [31:0] r_rd, s_addr, s_wdata;
  logic [3:0]  s_be;

  load_store_unit #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .rd_data(rd_data), .resp_valid(resp_valid), .stall(stall),
    .misaligned(misaligned), .illegal(illegal), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one access with the bus granting after gnt_wait REQ cycles (-1 = never)
  // and returning read data the cycle after the grant.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int gnt_wait);
    logic rv_pending;
    rv_pending = 1'b0;
    r_stall = 0; r_req = 0; r_ok = 1'b0; r_err = 1'b0; s_seen = 1'b0;
    r_rd = 32'h0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 40 && !r_ok; c++) begin
      #1;
      if (stall) r_stall++;
      if (bus_req) begin
        if (!s_seen) begin
          s_be = bus_be; s_addr = bus_addr; s_we = bus_we; s_wdata = bus_wdata;
        end
        s_seen = 1'b1;
        r_req++;
      end
      if (resp_valid) begin
        r_rd = rd_data; r_err = bus_err; r_ok = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
      end
      bus_rvalid = rv_pending;
      bus_rdata  = rv_pending ? rdat : 32'h0;
      bus_gnt    = bus_req && (gnt_wait >= 0) && (r_req > gnt_wait);
      rv_pending = bus_gnt && rd;
      @(negedge clk);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check_eq("resp_seen", {31'h0, r_ok}, 32'h1);
  endtask

  task automatic bad_req(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic exp_ill, input logic exp_mis);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'h5555AAAA;
    #1;
    check_eq({tag, "_illegal"}, {31'h0, illegal}, {31'h0, exp_ill});
    check_eq({tag, "_misal"}, {31'h0, misaligned}, {31'h0, exp_mis});
    check_eq({tag, "_stall"}, {31'h0, stall}, 32'h0);
    check_eq({tag, "_req"}, {31'h0, bus_req}, 32'h0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_eq({tag, "_pulse_end"}, {30'h0, illegal, misaligned}, 32'h0);
    check_eq({tag, "_req_after"}, {31'h0, bus_req}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_flags", {25'h0, resp_valid, stall, misaligned, illegal, bus_err, bus_req, bus_we}, 32'h0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_bus_be", {28'h0, bus_be}, 32'h0);

    // LW with gnt on first REQ cycle and rvalid one cycle later
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check_eq("lw_rd", r_rd, 32'hDEADBEEF);
    check_eq("lw_be", {28'h0, s_be}, 32'hF);
    check_eq("lw_addr", s_addr, 32'h100);
    check_eq("lw_we", {31'h0, s_we}, 32'h0);
    check_eq("lw_stall", r_stall, 3);
    check_eq("lw_err", {31'h0, r_err}, 32'h0);

    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0);
    check_eq("lb_rd", r_rd, 32'hFFFFFF80);
    check_eq("lb_be", {28'h0, s_be}, 32'h8);
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0);
    check_eq("lbu_rd", r_rd, 32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 0);
    check_eq("lh_rd", r_rd, 32'hFFFF80FF);
    check_eq("lh_be", {28'h0, s_be}, 32'hC);
    access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF7F01, 0);
    check_eq("lhu_rd", r_rd, 32'h000080FF);
    access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 2);
    check_eq("lb1_rd", r_rd, 32'h0000007F);
    check_eq("lb1_req_cycles", r_req, 3);
    check_eq("lb1_stall", r_stall, 5);

    // Stores: rd_data keeps the last load value (0x7F)
    access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0);
    check_eq("sb_we", {31'h0, s_we}, 32'h1);
    check_eq("sb_addr", s_addr, 32'h200);
    check_eq("sb_be", {28'h0, s_be}, 32'h2);
    check_eq("sb_wdata", s_wdata, 32'hABABABAB);
    check_eq("sb_stall", r_stall, 2);
    check_eq("sb_rd_hold", r_rd, 32'h0000007F);
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, 1);
    check_eq("sh_be", {28'h0, s_be}, 32'hC);
    check_eq("sh_wdata", s_wdata, 32'h12341234);
    access(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0);
    check_eq("sw_be", {28'h0, s_be}, 32'hF);
    check_eq("sw_wdata", s_wdata, 32'hCAFEF00D);

    // Rejected requests
    bad_req("lw_misal", 1'b1, 1'b0, 3'b010, 32'h102, 1'b0, 1'b1);
    bad_req("sh_misal", 1'b0, 1'b1, 3'b001, 32'h101, 1'b0, 1'b1);
    bad_req("sw_f3_100", 1'b0, 1'b1, 3'b100, 32'h200, 1'b1, 1'b0);
    bad_req("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h200, 1'b1, 1'b0);
    bad_req("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h200, 1'b1, 1'b0);

    // Timeout: grant never comes
    access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    check_eq("to_err", {31'h0, r_err}, 32'h1);
    check_eq("to_rd", r_rd, 32'h0);
    check_eq("to_req_cycles", r_req, 8);
    #1;
    check_eq("to_idle", {30'h0, stall, bus_req}, 32'h0);

    // Reset in WAIT, then a late rvalid
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; mem_read = 1'b0; rst = 1'b1;
    #1;
    check_eq("wait_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    #1;
    check_eq("rstw_flags", {25'h0, resp_valid, stall, misaligned, illegal, bus_err, bus_req, bus_we}, 32'h0);
    check_eq("rstw_rd", rd_data, 32'h0);
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #1;
    check_eq("late_rv_resp", {30'h0, resp_valid, stall}, 32'h0);
    check_eq("late_rv_rd", rd_data, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 0);
    check_eq("post_rst_lw", r_rd, 32'h0BADF00D);
    check_eq("post_rst_err", {31'h0, r_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
